// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable strobe generator on the 100 MHz system clock.
// Each channel counts to a latched limit, with fast/slow divisors, hold, single-step and resync.

module clk_enable_chan #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             hold,
    input  logic             step_edge,
    input  logic             slow_req,
    input  logic [CNT_W-1:0] div_fast,
    input  logic [CNT_W-1:0] div_slow,
    output logic             en,
    output logic             slow_act
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;

    // Limit and mode are only reloaded at a wrap or resync, so periods are never truncated.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            en       <= 1'b0;
            slow_act <= 1'b0;
            lim      <= div_fast;
        end else if (sync) begin
            cnt      <= '0;
            en       <= 1'b0;
            slow_act <= slow_req;
            lim      <= slow_req ? div_slow : div_fast;
        end else if (hold) begin
            en       <= step_edge;
        end else if (cnt == lim) begin
            cnt      <= '0;
            en       <= 1'b1;
            slow_act <= slow_req;
            lim      <= slow_req ? div_slow : div_fast;
        end else begin
            cnt      <= cnt + 1'b1;
            en       <= 1'b0;
        end
    end

endmodule

module clk_enable_gen #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 11
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [CHANNELS*CNT_W-1:0] DIV_FAST,
    input  logic [CHANNELS*CNT_W-1:0] DIV_SLOW,
    input  logic [CHANNELS-1:0]       SLOW_REQ,
    input  logic [CHANNELS-1:0]       HOLD,
    input  logic                      STEP,
    input  logic                      SYNC,
    output logic [CHANNELS-1:0]       EN,
    output logic [CHANNELS-1:0]       SLOW_ACT
);

    logic [CHANNELS-1:0][CNT_W-1:0] div_fast_a;
    logic [CHANNELS-1:0][CNT_W-1:0] div_slow_a;
    logic                           step_q;
    logic                           step_edge;

    assign div_fast_a = DIV_FAST;
    assign div_slow_a = DIV_SLOW;
    assign step_edge  = STEP & ~step_q;

    // Edge register keeps sampling through resync so a held STEP never re-fires.
    always_ff @(posedge CLK) begin
        if (RESET) step_q <= 1'b0;
        else       step_q <= STEP;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_enable_chan #(.CNT_W(CNT_W)) u_chan (
            .clk      (CLK),
            .rst      (RESET),
            .sync     (SYNC),
            .hold     (HOLD[i]),
            .step_edge(step_edge),
            .slow_req (SLOW_REQ[i]),
            .div_fast (div_fast_a[i]),
            .div_slow (div_slow_a[i]),
            .en       (EN[i]),
            .slow_act (SLOW_ACT[i])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against EN / SLOW_ACT.

module tb_clk_enable_gen;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [2:0][10:0] df, ds;
    logic [2:0]       SLOW_REQ, HOLD, EN, SLOW_ACT;
    logic             STEP, SYNC;

    clk_enable_gen #(.CHANNELS(3), .CNT_W(11)) dut (
        .CLK(CLK), .RESET(RESET), .DIV_FAST(df), .DIV_SLOW(ds),
        .SLOW_REQ(SLOW_REQ), .HOLD(HOLD), .STEP(STEP), .SYNC(SYNC),
        .EN(EN), .SLOW_ACT(SLOW_ACT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int    cyc;
        int    ch;
        bit    sa;
        bit    v;
        string nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 0;
    logic got;
    int   r, s;

    always @(posedge CLK) cyc++;

    // Monitor: compares every expectation tagged with the current cycle.
    always @(negedge CLK) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                got = q[i].sa ? SLOW_ACT[q[i].ch] : EN[q[i].ch];
                n_checks++;
                if (q[i].cyc < cyc || got !== q[i].v) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d ch=%0d %s got=%b exp=%b", q[i].nm, q[i].cyc,
                             q[i].ch, q[i].sa ? "SLOW_ACT" : "EN", got, q[i].v);
                end
                q.delete(i);
            end
        end
        if (done) begin
            foreach (q[i]) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s cyc=%0d never checked", q[i].nm, q[i].cyc);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic exp_one(input int c, input int ch, input bit sa, input bit v, input string nm);
        exp_t e;
        e.cyc = c; e.ch = ch; e.sa = sa; e.v = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic exp_range(input int ch, input int from, input int to, input bit v,
                             input string nm);
        for (int c = from; c <= to; c++) exp_one(c, ch, 1'b0, v, nm);
    endtask

    // EN high on every period-th cycle after base
    task automatic exp_per(input int ch, input int from, input int to, input int base,
                           input int period, input string nm);
        for (int c = from; c <= to; c++)
            exp_one(c, ch, 1'b0, (c > base) && ((c - base) % period == 0), nm);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        r = cyc;
    endtask

    initial begin
        RESET = 1'b1; STEP = 1'b0; SYNC = 1'b0; SLOW_REQ = '0; HOLD = '0;
        df = '0; ds = '0;

        // Basic division, continuous enable, mid-period divisor change, hold on /1
        df[0] = 11'd5; df[1] = 11'd3; df[2] = 11'd0;
        ds[0] = 11'd7; ds[1] = 11'd7; ds[2] = 11'd7;
        do_reset();
        for (int ch = 0; ch < 3; ch++) exp_one(r, ch, 1'b1, 1'b0, "reset_slow_act");
        exp_per(0, r, r + 24, r, 6, "div6");
        exp_per(1, r, r + 24, r, 4, "div4");
        exp_per(2, r, r + 24, r, 1, "div1");
        exp_per(0, r + 25, r + 30, r + 24, 6, "div_change_ignored");
        exp_per(0, r + 31, r + 36, r + 30, 3, "div_change_applied");
        exp_range(2, r + 25, r + 26, 1'b1, "div1_pre_hold");
        exp_range(2, r + 27, r + 29, 1'b0, "div1_held");
        exp_range(2, r + 30, r + 32, 1'b1, "div1_released");
        tick(26);
        df[0] = 11'd2; HOLD[2] = 1'b1;
        tick(3);
        HOLD[2] = 1'b0;
        tick(7);

        // Glitch-free fast/slow switching on ch1
        df[0] = 11'd5; df[1] = 11'd5; df[2] = 11'd0; ds[1] = 11'd1279;
        do_reset();
        exp_per(1, r + 1, r + 6, r, 6, "fast_period_completes");
        exp_one(r + 5, 1, 1'b1, 1'b0, "slow_act_before_wrap");
        exp_one(r + 6, 1, 1'b1, 1'b1, "slow_act_at_wrap");
        exp_range(1, r + 7, r + 1285, 1'b0, "slow_gap");
        exp_one(r + 1286, 1, 1'b0, 1'b1, "slow_period_1280");
        exp_one(r + 1285, 1, 1'b1, 1'b1, "slow_act_held");
        exp_one(r + 1286, 1, 1'b1, 1'b0, "slow_act_drop");
        exp_per(1, r + 1287, r + 1298, r + 1286, 6, "back_to_fast");
        tick(3);
        SLOW_REQ[1] = 1'b1;
        tick(697);
        SLOW_REQ[1] = 1'b0;
        tick(600);

        // Hold with remaining phase kept, single-step edges, hold+step same cycle
        df[0] = 11'd5; df[1] = 11'd3; df[2] = 11'd0;
        do_reset();
        exp_range(0, r + 1, r + 6, 1'b0, "pre_hold");
        exp_one(r + 7, 0, 1'b0, 1'b1, "step_pulse1");
        exp_range(0, r + 8, r + 10, 1'b0, "held_idle");
        exp_one(r + 11, 0, 1'b0, 1'b1, "step_pulse2");
        exp_range(0, r + 12, r + 25, 1'b0, "step_held_single");
        exp_one(r + 26, 0, 1'b0, 1'b1, "resume_phase");
        exp_per(0, r + 27, r + 32, r + 26, 6, "resume_period");
        exp_per(1, r, r + 32, r, 4, "step_ignored_unheld");
        exp_range(2, r + 1, r + 7, 1'b1, "hold_step_same_cycle");
        exp_range(2, r + 8, r + 10, 1'b0, "ch2_held");
        exp_one(r + 11, 2, 1'b0, 1'b1, "ch2_step");
        exp_range(2, r + 12, r + 23, 1'b0, "ch2_held2");
        exp_range(2, r + 24, r + 26, 1'b1, "ch2_released");
        tick(3);
        HOLD[0] = 1'b1;
        tick(3);
        STEP = 1'b1; HOLD[2] = 1'b1;
        tick(1);
        STEP = 1'b0;
        tick(3);
        STEP = 1'b1;
        tick(10);
        STEP = 1'b0;
        tick(3);
        HOLD = '0;
        tick(9);

        // Global resync, including a held channel reloading into slow mode
        df[0] = 11'd5; df[1] = 11'd3; df[2] = 11'd4; ds[2] = 11'd1;
        do_reset();
        s = r + 12;
        exp_per(0, r + 1, s - 1, r, 6, "pre_sync_ch0");
        exp_per(1, r + 1, s - 1, r + 1, 4, "pre_sync_ch1");
        exp_range(0, s, s, 1'b0, "sync_clears_ch0");
        exp_range(1, s, s, 1'b0, "sync_clears_ch1");
        exp_one(s - 1, 2, 1'b1, 1'b0, "held_no_reload");
        exp_one(s, 2, 1'b1, 1'b1, "sync_reload_slow");
        exp_per(0, s + 1, s + 24, s, 6, "post_sync_ch0");
        exp_per(1, s + 1, s + 24, s, 4, "post_sync_ch1");
        exp_per(2, s + 1, s + 8, s, 2, "post_sync_ch2");
        tick(1);
        HOLD = 3'b110; SLOW_REQ[2] = 1'b1;
        tick(1);
        HOLD = 3'b100;
        tick(9);
        SYNC = 1'b1;
        tick(1);
        SYNC = 1'b0; HOLD = '0;
        tick(24);

        // Reset mid-period: no trailing pulse, limit reloads from new DIV_FAST
        df[0] = 11'd5; df[1] = 11'd1; df[2] = 11'd0; ds[1] = 11'd2; SLOW_REQ = 3'b010;
        do_reset();
        exp_range(0, r + 1, r + 5, 1'b0, "pre_reset_ch0");
        exp_one(r + 1, 1, 1'b1, 1'b0, "slow_act_initial");
        exp_one(r + 2, 1, 1'b1, 1'b1, "slow_act_first_wrap");
        exp_one(r + 5, 1, 1'b1, 1'b1, "slow_act_before_reset");
        for (int ch = 0; ch < 3; ch++) begin
            exp_one(r + 6, ch, 1'b0, 1'b0, "reset_no_trailing_en");
            exp_one(r + 6, ch, 1'b1, 1'b0, "reset_clears_slow_act");
        end
        exp_per(0, r + 7, r + 14, r + 6, 4, "restart_new_fast");
        tick(5);
        RESET = 1'b1; df[0] = 11'd3;
        tick(1);
        RESET = 1'b0;
        tick(8);

        done = 1'b1;
        tick(2);
    end

endmodule
